// File: rtl/sram_arbiter_2ch_if.sv
// Two-channel client bus plus single-port SRAM macro signals, seen from the arbiter (slave)
// and from the clients/SRAM side (master).
interface sram_arbiter_2ch_if #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8
);
  logic                 req0;
  logic                 req1;
  logic                 we0;
  logic                 we1;
  logic [ADDRWIDTH-1:0] addr0;
  logic [ADDRWIDTH-1:0] addr1;
  logic [DATAWIDTH-1:0] wdata0;
  logic [DATAWIDTH-1:0] wdata1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 rvalid0;
  logic                 rvalid1;
  logic [DATAWIDTH-1:0] rdata0;
  logic [DATAWIDTH-1:0] rdata1;
  logic                 init_done;
  logic                 mem_wr_en;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_din;
  logic [DATAWIDTH-1:0] mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, init_done,
    output mem_wr_en, mem_addr, mem_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, init_done,
    input  mem_wr_en, mem_addr, mem_din
  );
endinterface

// File: rtl/sram_arbiter_2ch.sv
// Round-robin arbiter sharing one single-port SRAM between two channels; clears the array after reset.
// Grant is combinational, read data 1 cycle after grant; a requester holds req until granted.
module sram_arbiter_2ch #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  sram_arbiter_2ch_if.slave bus
);
  localparam int                 DEPTH    = 2 ** ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] LAST_CNT = (ADDRWIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDRWIDTH:0] CNT_ONE  = (ADDRWIDTH + 1)'(1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDRWIDTH:0]   r_init_cnt;
  logic                 r_last;
  logic                 r_rvalid0;
  logic                 r_rvalid1;
  logic [DATAWIDTH-1:0] r_rdata0;
  logic [DATAWIDTH-1:0] r_rdata1;

  logic                 w_gnt0;
  logic                 w_gnt1;
  logic                 w_mem_wr_en;
  logic [ADDRWIDTH-1:0] w_mem_addr;
  logic [DATAWIDTH-1:0] w_mem_din;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_mem_wr_en = 1'b0;
    w_mem_addr  = '0;
    w_mem_din   = '0;
    case (r_state)
      S_INIT: begin
        w_mem_wr_en = 1'b1;
        w_mem_addr  = r_init_cnt[ADDRWIDTH-1:0];
        if (r_init_cnt == LAST_CNT) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // On contention the channel not served last wins; r_last resets to 1 so ch0 wins first.
        if (bus.req0 && (!bus.req1 || r_last)) begin
          w_gnt0 = 1'b1;
        end else if (bus.req1) begin
          w_gnt1 = 1'b1;
        end
        if (w_gnt0) begin
          w_mem_wr_en = bus.we0;
          w_mem_addr  = bus.addr0;
          w_mem_din   = bus.wdata0;
        end else if (w_gnt1) begin
          w_mem_wr_en = bus.we1;
          w_mem_addr  = bus.addr1;
          w_mem_din   = bus.wdata1;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_last     <= 1'b1;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_init_cnt <= r_init_cnt + CNT_ONE;
      end
      if (w_gnt0) begin
        r_last <= 1'b0;
      end else if (w_gnt1) begin
        r_last <= 1'b1;
      end
      // Async SRAM read: mem_dout already reflects the granted address at this edge.
      r_rvalid0 <= w_gnt0 && !bus.we0;
      r_rvalid1 <= w_gnt1 && !bus.we1;
      if (w_gnt0 && !bus.we0) begin
        r_rdata0 <= bus.mem_dout;
      end
      if (w_gnt1 && !bus.we1) begin
        r_rdata1 <= bus.mem_dout;
      end
    end
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.init_done = (r_state == S_RUN);
  assign bus.mem_wr_en = w_mem_wr_en;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_din   = w_mem_din;
endmodule

// File: tb/tb_sram_arbiter_2ch.sv
// Directed bench for sram_arbiter_2ch (ADDRWIDTH=4, DATAWIDTH=8) with a behavioural
// sync-write / async-read SRAM preloaded with non-zero contents.
module tb_sram_arbiter_2ch;
  logic clk;
  logic reset;
  logic fill_en;
  int   checks;
  int   failures;

  logic [7:0] mem [16];

  sram_arbiter_2ch_if #(.DATAWIDTH(8), .ADDRWIDTH(4)) bus ();

  sram_arbiter_2ch #(.DATAWIDTH(8), .ADDRWIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hF0 | 8'(i);
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_din;
    end
  end
  assign bus.mem_dout = mem[bus.mem_addr];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] t5_addr [4];
  logic [7:0] t5_exp  [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    t5_addr  = '{4'd3, 4'd0, 4'd3, 4'd0};
    t5_exp   = '{8'hA5, 8'h00, 8'hA5, 8'h00};
    reset    = 1'b1;
    fill_en  = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    // One reset cycle; the same edge preloads the SRAM with garbage.
    next_cycle();
    reset   = 1'b0;
    fill_en = 1'b0;
    check_val("rst_rvalid0", bus.rvalid0, 0);
    check_val("rst_rvalid1", bus.rvalid1, 0);
    check_val("rst_rdata0", bus.rdata0, 0);
    check_val("rst_rdata1", bus.rdata1, 0);
    check_val("mem_garbage", mem[9], 8'hF9);

    // Clear sweep: a held read request must be ignored until the sweep ends.
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd5;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_val($sformatf("init_wr_en[%0d]", i), bus.mem_wr_en, 1);
      check_val($sformatf("init_addr[%0d]", i), bus.mem_addr, i);
      check_val($sformatf("init_din[%0d]", i), bus.mem_din, 0);
      check_val($sformatf("init_gnt0[%0d]", i), bus.gnt0, 0);
      check_val($sformatf("init_gnt1[%0d]", i), bus.gnt1, 0);
      check_val($sformatf("init_done_lo[%0d]", i), bus.init_done, 0);
      next_cycle();
    end
    @(negedge clk);
    check_val("init_done_hi", bus.init_done, 1);
    check_val("first_run_gnt0", bus.gnt0, 1);
    next_cycle();

    // ch0 alone reads every address back-to-back; all cleared.
    for (int a = 0; a < 16; a++) begin
      bus.addr0 = 4'(a);
      @(negedge clk);
      check_val($sformatf("rd_gnt0[%0d]", a), bus.gnt0, 1);
      check_val($sformatf("rd_rvalid0[%0d]", a), bus.rvalid0, 1);
      check_val($sformatf("rd_rdata0[%0d]", a), bus.rdata0, 0);
      next_cycle();
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    check_val("rd_last_rvalid0", bus.rvalid0, 1);
    check_val("rd_last_rdata0", bus.rdata0, 0);
    check_val("idle_gnt0", bus.gnt0, 0);
    check_val("idle_wr_en", bus.mem_wr_en, 0);
    next_cycle();
    @(negedge clk);
    check_val("rvalid0_pulse", bus.rvalid0, 0);
    next_cycle();

    // ch0 writes 0xA5@3, ch1 reads @3 on the very next cycle.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd3; bus.wdata0 = 8'hA5;
    @(negedge clk);
    check_val("wr_gnt0", bus.gnt0, 1);
    check_val("wr_mem_wr_en", bus.mem_wr_en, 1);
    check_val("wr_mem_addr", bus.mem_addr, 3);
    check_val("wr_mem_din", bus.mem_din, 8'hA5);
    next_cycle();
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd3;
    @(negedge clk);
    check_val("raw_gnt1", bus.gnt1, 1);
    check_val("raw_rvalid0_write", bus.rvalid0, 0);
    check_val("raw_mem_wr_en", bus.mem_wr_en, 0);
    next_cycle();
    bus.req1 = 1'b0;
    @(negedge clk);
    check_val("raw_rvalid1", bus.rvalid1, 1);
    check_val("raw_rdata1", bus.rdata1, 8'hA5);
    next_cycle();

    // Contention: ch1 was served last, so ch0 wins first, then strict alternation.
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd1;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val($sformatf("rr_gnt0[%0d]", k), bus.gnt0, (k % 2 == 0) ? 1 : 0);
      check_val($sformatf("rr_gnt1[%0d]", k), bus.gnt1, (k % 2 == 1) ? 1 : 0);
      check_val($sformatf("rr_addr[%0d]", k), bus.mem_addr, (k % 2 == 0) ? 1 : 2);
      next_cycle();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    check_val("rr_tail_rvalid1", bus.rvalid1, 1);
    check_val("rr_tail_rvalid0", bus.rvalid0, 0);
    next_cycle();

    // ch1 alone for 4 cycles: granted every cycle, data one cycle later.
    bus.req1 = 1'b1; bus.we1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.addr1 = t5_addr[k];
      @(negedge clk);
      check_val($sformatf("solo_gnt1[%0d]", k), bus.gnt1, 1);
      check_val($sformatf("solo_gnt0[%0d]", k), bus.gnt0, 0);
      if (k > 0) begin
        check_val($sformatf("solo_rvalid1[%0d]", k), bus.rvalid1, 1);
        check_val($sformatf("solo_rdata1[%0d]", k), bus.rdata1, t5_exp[k-1]);
      end
      next_cycle();
    end
    bus.req1 = 1'b0;
    @(negedge clk);
    check_val("solo_tail_rvalid1", bus.rvalid1, 1);
    check_val("solo_tail_rdata1", bus.rdata1, t5_exp[3]);
    next_cycle();
    @(negedge clk);
    check_val("solo_rvalid1_pulse", bus.rvalid1, 0);
    next_cycle();

    // Write 0x3C@7 and confirm it landed.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd7; bus.wdata0 = 8'h3C;
    @(negedge clk);
    check_val("w7_gnt0", bus.gnt0, 1);
    next_cycle();
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd7;
    next_cycle();
    bus.req1 = 1'b0;
    @(negedge clk);
    check_val("w7_rdata1", bus.rdata1, 8'h3C);
    next_cycle();

    // Reset mid-RUN with a read of @7 pending at the reset edge.
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd7;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_val("mrst_rvalid0", bus.rvalid0, 0);
    check_val("mrst_rdata1", bus.rdata1, 0);
    check_val("mrst_init_done", bus.init_done, 0);
    check_val("mrst_gnt0", bus.gnt0, 0);
    check_val("mrst_addr", bus.mem_addr, 0);
    for (int i = 1; i <= 5; i++) next_cycle();
    @(negedge clk);
    check_val("mrst_cnt5_addr", bus.mem_addr, 5);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_val($sformatf("sweep2_addr[%0d]", i), bus.mem_addr, i);
      check_val($sformatf("sweep2_gnt0[%0d]", i), bus.gnt0, 0);
      next_cycle();
    end
    @(negedge clk);
    check_val("sweep2_done", bus.init_done, 1);
    check_val("sweep2_gnt0", bus.gnt0, 1);
    next_cycle();
    bus.req0 = 1'b0;
    @(negedge clk);
    check_val("post_rst_rvalid0", bus.rvalid0, 1);
    check_val("post_rst_rdata0", bus.rdata0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
